uart_cmd_arb: RTL and testbench

//  Two-requester round-robin controller for the 16-bit UART command engine. Grants one

---
 rtl/uart_cmd_arb_if.sv | 44 ++++
 rtl/uart_cmd_arb.sv | 166 ++++++++++++++++
 tb/tb_uart_cmd_arb.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_arb_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_arb_if
//   Command/response bus between the round-robin command controller and the
//   16-bit UART command engine.
//
//   uart_cmd       controller -> engine   latched command word
//   uart_cmd_vld   controller -> engine   command valid
//   uart_cmd_rdy   engine -> controller   engine idle/accept; low while busy,
//                                         rises again at frame end
//   uart_read_rdy  engine -> controller   received-byte strobe
//   uart_read_data engine -> controller   [READ_WIDTH-1:0] byte,
//                                         [READ_WIDTH] parity-error flag
//
//   modport master : the controller side
//   modport slave  : the UART engine side
// ---------------------------------------------------------------------------
interface uart_cmd_arb_if #(
   parameter int CMD_WIDTH  = 16,
   parameter int READ_WIDTH = 8
) ();

   logic [CMD_WIDTH-1:0] uart_cmd;
   logic                 uart_cmd_vld;
   logic                 uart_cmd_rdy;
   logic                 uart_read_rdy;
   logic [READ_WIDTH:0]  uart_read_data;

   modport master (
      output uart_cmd,
      output uart_cmd_vld,
      input  uart_cmd_rdy,
      input  uart_read_rdy,
      input  uart_read_data
   );

   modport slave (
      input  uart_cmd,
      input  uart_cmd_vld,
      output uart_cmd_rdy,
      output uart_read_rdy,
      output uart_read_data
   );

endinterface

// File: rtl/uart_cmd_arb.sv
// ---------------------------------------------------------------------------
// uart_cmd_arb
//   Two-requester round-robin controller for the UART command engine. One
//   requester is granted at a time; its command is issued over the
//   uart_cmd_vld/uart_cmd_rdy handshake, the controller waits for the frame
//   to complete (and, for reads, for the returned byte), then returns a
//   one-cycle response pulse with shared data/status to the owner.
//
//   clk, rst_n            clock, asynchronous active-low reset
//   reqN_vld / reqN_cmd   requester N command valid / command word
//   reqN_rdy              requester N accepted (combinational, IDLE only)
//   rspN_vld              one-cycle response pulse to requester N
//   rsp_data              read byte (0 for writes and timeouts)
//   rsp_err               00 ok, 01 timeout, 10 parity error
//   uart                  engine bus (master side)
// ---------------------------------------------------------------------------
module uart_cmd_arb #(
   parameter int CMD_WIDTH  = 16,
   parameter int READ_WIDTH = 8,
   parameter int TIMEOUT    = 20000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0_vld,
   input  logic [CMD_WIDTH-1:0]  req0_cmd,
   output logic                  req0_rdy,
   input  logic                  req1_vld,
   input  logic [CMD_WIDTH-1:0]  req1_cmd,
   output logic                  req1_rdy,
   output logic                  rsp0_vld,
   output logic                  rsp1_vld,
   output logic [READ_WIDTH-1:0] rsp_data,
   output logic [1:0]            rsp_err,
   uart_cmd_arb_if.master        uart
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_ISSUE     = 3'd1;
   localparam logic [2:0] S_BLANK     = 3'd2;
   localparam logic [2:0] S_WAIT_DONE = 3'd3;
   localparam logic [2:0] S_WAIT_RD   = 3'd4;
   localparam logic [2:0] S_RESP      = 3'd5;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;

   // Wide enough to hold TIMEOUT itself: a read whose frame completes on
   // the last allowed cycle steps the timer one past TIMEOUT-1 in WAIT_RD.
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [2:0]            state;
   logic                  ptr;      // requester with priority this round
   logic                  owner;    // requester currently being served
   logic                  grant;
   logic [CMD_WIDTH-1:0]  cmd_q;
   logic [TW-1:0]         timer;
   logic [READ_WIDTH-1:0] rsp_data_q;
   logic [1:0]            rsp_err_q;
   logic                  time_up;

   // Pointer side wins when it is requesting, otherwise the other side.
   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      grant = ptr;
      if (!ptr && !req0_vld) grant = 1'b1;
      if ( ptr && !req1_vld) grant = 1'b0;
   end

   assign req0_rdy = (state == S_IDLE) && !grant && req0_vld;
   assign req1_rdy = (state == S_IDLE) &&  grant && req1_vld;

   assign time_up  = (timer >= TW'(TIMEOUT - 1));

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         ptr        <= 1'b0;
         owner      <= 1'b0;
         cmd_q      <= '0;
         timer      <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= ERR_OK;
      end else begin
         case (state)
            S_IDLE: begin
               if (req0_rdy) begin
                  cmd_q <= req0_cmd;
                  owner <= 1'b0;
                  state <= S_ISSUE;
               end else if (req1_rdy) begin
                  cmd_q <= req1_cmd;
                  owner <= 1'b1;
                  state <= S_ISSUE;
               end
            end

            // No timeout here: the engine is required to accept eventually.
            S_ISSUE: begin
               if (uart.uart_cmd_rdy) begin
                  timer <= '0;
                  state <= S_BLANK;
               end
            end

            // Engine drops rdy one cycle late; its stale high is skipped.
            S_BLANK: begin
               timer <= timer + 1'b1;
               state <= S_WAIT_DONE;
            end

            // Completion is tested before the timeout so it wins a tie.
            S_WAIT_DONE: begin
               if (uart.uart_cmd_rdy) begin
                  if (cmd_q[CMD_WIDTH-1]) begin
                     timer <= timer + 1'b1;
                     state <= S_WAIT_RD;
                  end else begin
                     rsp_data_q <= '0;
                     rsp_err_q  <= ERR_OK;
                     state      <= S_RESP;
                  end
               end else if (time_up) begin
                  rsp_data_q <= '0;
                  rsp_err_q  <= ERR_TIMEOUT;
                  state      <= S_RESP;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            S_WAIT_RD: begin
               if (uart.uart_read_rdy) begin
                  rsp_data_q <= uart.uart_read_data[READ_WIDTH-1:0];
                  rsp_err_q  <= {uart.uart_read_data[READ_WIDTH], 1'b0};
                  state      <= S_RESP;
               end else if (time_up) begin
                  rsp_data_q <= '0;
                  rsp_err_q  <= ERR_TIMEOUT;
                  state      <= S_RESP;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            S_RESP: begin
               ptr   <= ~owner;
               state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   // Decoded from registered state so reset clears them asynchronously.
   assign uart.uart_cmd     = cmd_q;
   assign uart.uart_cmd_vld = (state == S_ISSUE);
   assign rsp0_vld          = (state == S_RESP) && !owner;
   assign rsp1_vld          = (state == S_RESP) &&  owner;
   assign rsp_data          = rsp_data_q;
   assign rsp_err           = rsp_err_q;

endmodule

// File: tb/tb_uart_cmd_arb.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_arb
//   Self-checking bench for uart_cmd_arb: a behavioural UART engine, two
//   requester drivers and a scoreboard of expected responses per requester
//   plus the expected service order.
// ---------------------------------------------------------------------------
module tb_uart_cmd_arb;

   localparam int CW = 16;
   localparam int RW = 8;
   localparam int TO = 100;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0_vld, req1_vld;
   logic [CW-1:0] req0_cmd, req1_cmd;
   logic          req0_rdy, req1_rdy;
   logic          rsp0_vld, rsp1_vld;
   logic [RW-1:0] rsp_data;
   logic [1:0]    rsp_err;

   always #5 clk = ~clk;

   uart_cmd_arb_if #(.CMD_WIDTH(CW), .READ_WIDTH(RW)) uart ();

   uart_cmd_arb #(.CMD_WIDTH(CW), .READ_WIDTH(RW), .TIMEOUT(TO)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req0_vld (req0_vld),
      .req0_cmd (req0_cmd),
      .req0_rdy (req0_rdy),
      .req1_vld (req1_vld),
      .req1_cmd (req1_cmd),
      .req1_rdy (req1_rdy),
      .rsp0_vld (rsp0_vld),
      .rsp1_vld (rsp1_vld),
      .rsp_data (rsp_data),
      .rsp_err  (rsp_err),
      .uart     (uart.master)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [RW-1:0] data;
      logic [1:0]    err;
      bit            timed;
   } exp_t;

   exp_t          q0[$];
   exp_t          q1[$];
   int            order_q[$];
   logic [CW-1:0] cmd_q[$];

   task automatic expect_rsp(input int idx, input logic [RW-1:0] d, input logic [1:0] e, input bit timed);
      exp_t x;
      x.data  = d;
      x.err   = e;
      x.timed = timed;
      if (idx == 0) q0.push_back(x);
      else          q1.push_back(x);
      order_q.push_back(idx);
   endtask

   // ---------------- UART engine model ----------------
   int          eng_acc_dly  = 1;
   int          eng_done_dly = 5;
   int          eng_rd_dly   = 2;
   logic [RW:0] eng_rd_data  = '0;
   bit          eng_no_read  = 1'b0;
   bit          stray_req    = 1'b0;
   int          eng_frames   = 0;
   int          evt_cyc      = 0;
   int          accept_cyc   = 0;

   initial begin
      logic [CW-1:0] cur;
      uart.uart_cmd_rdy   = 1'b0;
      uart.uart_read_rdy  = 1'b0;
      uart.uart_read_data = '0;
      forever begin
         @(negedge clk);
         if (rst_n && uart.uart_cmd_vld) begin
            cur = uart.uart_cmd;
            if (cmd_q.size() == 0) check("cmd_unexpected", 1, 0);
            else                   check("uart_cmd", cur, cmd_q.pop_front());
            repeat (eng_acc_dly) @(negedge clk);
            uart.uart_cmd_rdy = 1'b1;
            accept_cyc = cyc + 1;
            @(negedge clk);
            check("cmd_vld_drop", uart.uart_cmd_vld, 0);
            @(negedge clk);
            uart.uart_cmd_rdy = 1'b0;
            repeat (eng_done_dly) @(negedge clk);
            uart.uart_cmd_rdy = 1'b1;
            evt_cyc = cyc;
            @(negedge clk);
            uart.uart_cmd_rdy = 1'b0;
            if (cur[CW-1] && !eng_no_read) begin
               repeat (eng_rd_dly) @(negedge clk);
               uart.uart_read_rdy  = 1'b1;
               uart.uart_read_data = eng_rd_data;
               evt_cyc = cyc;
               @(negedge clk);
               uart.uart_read_rdy  = 1'b0;
            end
            eng_frames++;
         end else if (stray_req) begin
            uart.uart_read_rdy  = 1'b1;
            uart.uart_read_data = 9'h033;
            @(negedge clk);
            uart.uart_read_rdy  = 1'b0;
            stray_req = 1'b0;
         end
      end
   end

   // ---------------- response monitor ----------------
   initial begin
      bit   prev_rsp = 1'b0;
      int   own;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && (rsp0_vld || rsp1_vld)) begin
            check("rsp_one_hot", rsp0_vld && rsp1_vld, 0);
            check("rsp_pulse_width", prev_rsp, 0);
            own = rsp1_vld ? 1 : 0;
            if (order_q.size() == 0) begin
               check("rsp_unexpected", 1, 0);
            end else begin
               check("rsp_owner", own, order_q.pop_front());
               if ((own == 0 && q0.size() == 0) || (own == 1 && q1.size() == 0)) begin
                  check("rsp_no_expect", 1, 0);
               end else begin
                  e = (own == 0) ? q0.pop_front() : q1.pop_front();
                  check("rsp_data", rsp_data, e.data);
                  check("rsp_err", rsp_err, e.err);
                  if (e.timed) check("timeout_latency", cyc - accept_cyc, TO);
                  else         check("rsp_latency", cyc - evt_cyc, 1);
               end
            end
         end
         prev_rsp = rst_n && (rsp0_vld || rsp1_vld);
      end
   end

   // ---------------- requester driver ----------------
   task automatic send(input int idx, input logic [CW-1:0] cmd);
      int n = 0;
      @(negedge clk);
      if (idx == 0) begin req0_vld = 1'b1; req0_cmd = cmd; end
      else          begin req1_vld = 1'b1; req1_cmd = cmd; end
      #1;
      while (!(idx == 0 ? req0_rdy : req1_rdy) && n < 2000) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 2000) check("accept_wait_expired", 1, 0);
      @(posedge clk);
      @(negedge clk);
      if (idx == 0) req0_vld = 1'b0;
      else          req1_vld = 1'b0;
      check("cmd_vld_latency", uart.uart_cmd_vld, 1);
   endtask

   task automatic wait_rsps();
      int n = 0;
      while (order_q.size() > 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) check("rsp_wait_expired", order_q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req0_rdy"}, req0_rdy, 0);
      check({tag, "_req1_rdy"}, req1_rdy, 0);
      check({tag, "_rsp0_vld"}, rsp0_vld, 0);
      check({tag, "_rsp1_vld"}, rsp1_vld, 0);
      check({tag, "_rsp_data"}, rsp_data, 0);
      check({tag, "_rsp_err"}, rsp_err, 0);
      check({tag, "_uart_cmd"}, uart.uart_cmd, 0);
      check({tag, "_uart_cmd_vld"}, uart.uart_cmd_vld, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      int n;
      rst_n    = 1'b0;
      req0_vld = 1'b0;
      req1_vld = 1'b0;
      req0_cmd = '0;
      req1_cmd = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      // T1: write from requester 0, slow accept and long frame
      eng_acc_dly = 3; eng_done_dly = 50;
      cmd_q.push_back(16'h1234);
      expect_rsp(0, 8'h00, 2'b00, 1'b0);
      send(0, 16'h1234);
      wait_rsps();

      // T2: read from requester 1
      eng_acc_dly = 1; eng_done_dly = 10; eng_rd_dly = 2; eng_rd_data = 9'h0A5; eng_no_read = 1'b0;
      cmd_q.push_back(16'h8055);
      expect_rsp(1, 8'hA5, 2'b00, 1'b0);
      send(1, 16'h8055);
      wait_rsps();

      // T3: simultaneous requests, pointer at 0 -> req0 first, twice
      eng_done_dly = 4;
      for (int r = 0; r < 2; r++) begin
         cmd_q.push_back(16'h0101 + 16'(r));
         cmd_q.push_back(16'h0202 + 16'(r));
         expect_rsp(0, 8'h00, 2'b00, 1'b0);
         expect_rsp(1, 8'h00, 2'b00, 1'b0);
         fork
            send(0, 16'h0101 + 16'(r));
            send(1, 16'h0202 + 16'(r));
         join
         wait_rsps();
      end

      // T3b: req0 alone moves the pointer to 1, then both -> req1 first
      cmd_q.push_back(16'h0505);
      expect_rsp(0, 8'h00, 2'b00, 1'b0);
      send(0, 16'h0505);
      wait_rsps();
      cmd_q.push_back(16'h0707);
      cmd_q.push_back(16'h0606);
      expect_rsp(1, 8'h00, 2'b00, 1'b0);
      expect_rsp(0, 8'h00, 2'b00, 1'b0);
      fork
         send(0, 16'h0606);
         send(1, 16'h0707);
      join
      wait_rsps();

      // T4: read with no returned byte -> timeout exactly TO cycles after accept
      eng_acc_dly = 2; eng_done_dly = 20; eng_no_read = 1'b1;
      cmd_q.push_back(16'h8001);
      expect_rsp(0, 8'h00, 2'b01, 1'b1);
      send(0, 16'h8001);
      wait_rsps();

      // T5: parity error on returned byte, then a stray strobe in IDLE
      eng_acc_dly = 1; eng_done_dly = 6; eng_no_read = 1'b0; eng_rd_data = 9'h1FF;
      cmd_q.push_back(16'h80AA);
      expect_rsp(1, 8'hFF, 2'b10, 1'b0);
      send(1, 16'h80AA);
      wait_rsps();
      stray_req = 1'b1;
      n = 0;
      while (stray_req && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("stray_wait_expired", 1, 0);
      repeat (5) @(negedge clk);
      check("stray_hold_data", rsp_data, 8'hFF);
      check("stray_hold_err", rsp_err, 2'b10);

      // T6: reset while waiting for the read byte
      eng_acc_dly = 1; eng_done_dly = 5; eng_no_read = 1'b1;
      cmd_q.push_back(16'h8077);
      n = eng_frames;
      send(0, 16'h8077);
      while (eng_frames == n && cyc < 40000) @(negedge clk);
      if (eng_frames == n) check("frame_wait_expired", 1, 0);
      repeat (3) @(negedge clk);
      check("pre_reset_cmd", uart.uart_cmd, 16'h8077);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (TO + 10) @(negedge clk);

      eng_done_dly = 4; eng_no_read = 1'b0;
      cmd_q.push_back(16'h4321);
      expect_rsp(0, 8'h00, 2'b00, 1'b0);
      send(0, 16'h4321);
      wait_rsps();

      check("pending_rsp", order_q.size(), 0);
      check("pending_cmd", cmd_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
